// File: rtl/light_day_night_ctrl.sv
// Day/night controller for the pet: synchronizes the LDR input, samples it on
// a prescaled tick, commits a light/dark change only after STABLE_COUNT
// consecutive differing samples, and reports each change as a held event
// with a valid/ack handshake.
module light_day_night_ctrl #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int STABLE_COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_input,
  input  logic enable,
  input  logic evt_ack,
  output logic light_state,
  output logic evt_valid,
  output logic evt_is_night,
  output logic sample_tick
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {S_OFF, S_TRACK, S_CONFIRM, S_NOTIFY} state_t;

  state_t        state, nxt;
  logic [1:0]    sync_q;
  logic          samp;
  logic [PW-1:0] pre_cnt;
  logic [CW-1:0] stab_cnt;
  logic          tick, diff;
  logic          commit, ack_clr, cnt_clr, cnt_one, cnt_inc;

  assign samp        = sync_q[1];
  assign tick        = enable && (pre_cnt == PRE_MAX);
  assign diff        = (samp != light_state);
  assign sample_tick = tick;

  // Two-flop synchronizer for the asynchronous sensor input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sensor_input};
  end

  // Sample prescaler; parked at zero while monitoring is disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  pre_cnt <= '0;
    else if (!enable)            pre_cnt <= '0;
    else if (pre_cnt == PRE_MAX) pre_cnt <= '0;
    else                         pre_cnt <= pre_cnt + PW'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_OFF;
    else        state <= nxt;
  end

  // Next-state logic; disable overrides everything else
  always_comb begin
    nxt = state;
    if (!enable) nxt = S_OFF;
    else begin
      case (state)
        S_OFF:     nxt = S_TRACK;
        S_TRACK:   if (tick && diff) nxt = (STABLE_COUNT == 1) ? S_NOTIFY : S_CONFIRM;
        S_CONFIRM: if (tick) begin
                     if (!diff)                    nxt = S_TRACK;
                     else if (stab_cnt == CNT_MAX) nxt = S_NOTIFY;
                   end
        S_NOTIFY:  if (evt_ack && evt_valid) nxt = S_TRACK;
        default:   nxt = S_OFF;
      endcase
    end
  end

  // Datapath control strobes decoded from state and the current sample
  always_comb begin
    commit  = 1'b0;
    ack_clr = 1'b0;
    cnt_clr = 1'b0;
    cnt_one = 1'b0;
    cnt_inc = 1'b0;
    if (enable) begin
      case (state)
        S_TRACK: if (tick && diff) begin
                   if (STABLE_COUNT == 1) commit  = 1'b1;
                   else                   cnt_one = 1'b1;
                 end
        S_CONFIRM: if (tick) begin
                     if (!diff)                    cnt_clr = 1'b1;
                     else if (stab_cnt == CNT_MAX) commit  = 1'b1;
                     else                          cnt_inc = 1'b1;
                   end
        S_NOTIFY: ack_clr = evt_ack && evt_valid;
        default: ;
      endcase
    end
  end

  // Stable counter, committed condition and event registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt     <= '0;
      light_state  <= 1'b0;
      evt_valid    <= 1'b0;
      evt_is_night <= 1'b0;
    end else if (!enable) begin
      // pending event is dropped; light_state keeps its committed value
      stab_cnt  <= '0;
      evt_valid <= 1'b0;
    end else if (commit) begin
      light_state  <= samp;
      evt_is_night <= ~samp;
      evt_valid    <= 1'b1;
      stab_cnt     <= '0;
    end else if (ack_clr) begin
      evt_valid <= 1'b0;
    end else if (cnt_clr) begin
      stab_cnt <= '0;
    end else if (cnt_one) begin
      stab_cnt <= CW'(1);
    end else if (cnt_inc) begin
      stab_cnt <= stab_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_light_day_night_ctrl.sv
// Directed bench for light_day_night_ctrl: SAMPLE_DIV=4 with STABLE_COUNT=3
// for the main scenarios, and a STABLE_COUNT=1 instance on shared inputs.
module tb_light_day_night_ctrl;

  logic clk = 1'b0;
  logic reset, sensor_input, enable, evt_ack;
  logic light3, valid3, night3, tick3;
  logic light1, valid1, night1, tick1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  light_day_night_ctrl #(.SAMPLE_DIV(4), .STABLE_COUNT(3)) dut3 (
    .clk(clk), .reset(reset), .sensor_input(sensor_input), .enable(enable),
    .evt_ack(evt_ack), .light_state(light3), .evt_valid(valid3),
    .evt_is_night(night3), .sample_tick(tick3));

  light_day_night_ctrl #(.SAMPLE_DIV(4), .STABLE_COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .sensor_input(sensor_input), .enable(enable),
    .evt_ack(evt_ack), .light_state(light1), .evt_valid(valid1),
    .evt_is_night(night1), .sample_tick(tick1));

  // advance n rising edges, then settle 1 time unit
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // step until the prescaler tick is visible (count at SAMPLE_DIV-1)
  task automatic align();
    bit found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (tick3 === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL align: no sample_tick within 8 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sensor_input = 1'b1; enable = 1'b1; evt_ack = 1'b0;
    #2;
    checks++;
    if ({light3, valid3, night3, tick3} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b want 0000", {light3, valid3, night3, tick3});
    end
    @(negedge clk);
    sensor_input = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_idle();
    int ticks = 0, last = -1, bad_gap = 0, bad_out = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (tick3 === 1'b1) begin
        if (last >= 0 && i - last != 4) bad_gap++;
        last = i;
        ticks++;
      end
      if (valid3 !== 1'b0 || light3 !== 1'b0) bad_out++;
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL idle_tick_count: got %0d want 10", ticks);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL idle_tick_gap: %0d gaps not equal to 4", bad_gap);
    end
    checks++;
    if (bad_out != 0) begin
      errors++;
      $display("FAIL idle_outputs: %0d cycles with evt_valid/light_state nonzero", bad_out);
    end
  endtask

  task automatic test_to_day();
    int bad = 0;
    align();
    sensor_input = 1'b1;
    step(12);
    checks++;
    if (valid3 !== 1'b0) begin
      errors++;
      $display("FAIL day_early: evt_valid=%b want 0", valid3);
    end
    step(1);
    checks++;
    if ({light3, valid3, night3} !== 3'b110) begin
      errors++;
      $display("FAIL day_commit: light/valid/night=%b want 110", {light3, valid3, night3});
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      if ({light3, valid3, night3} !== 3'b110) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL day_hold: %0d cycles not holding 110", bad);
    end
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    checks++;
    if (valid3 !== 1'b0 || light3 !== 1'b1) begin
      errors++;
      $display("FAIL day_ack: valid=%b light=%b want 0 1", valid3, light3);
    end
  endtask

  task automatic test_glitch_then_night();
    int bad = 0;
    align();
    sensor_input = 1'b0;
    step(9);
    sensor_input = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (valid3 !== 1'b0 || light3 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_reject: %0d cycles with event or light change", bad);
    end
    align();
    sensor_input = 1'b0;
    step(12);
    checks++;
    if (valid3 !== 1'b0) begin
      errors++;
      $display("FAIL night_early: evt_valid=%b want 0", valid3);
    end
    step(1);
    checks++;
    if ({light3, valid3, night3} !== 3'b011) begin
      errors++;
      $display("FAIL night_commit: light/valid/night=%b want 011", {light3, valid3, night3});
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    sensor_input = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if ({light3, valid3, night3} !== 3'b011) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL notify_hold: %0d cycles changed while pending", bad);
    end
    align();
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    checks++;
    if (valid3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack: evt_valid=%b want 0", valid3);
    end
    step(11);
    checks++;
    if (valid3 !== 1'b0 || light3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early: valid=%b light=%b want 0 0", valid3, light3);
    end
    step(1);
    checks++;
    if ({light3, valid3, night3} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_commit: light/valid/night=%b want 110", {light3, valid3, night3});
    end
  endtask

  task automatic test_disable();
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    align();
    sensor_input = 1'b0;
    step(9);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(2);
    checks++;
    if (tick3 !== 1'b0 || valid3 !== 1'b0) begin
      errors++;
      $display("FAIL dis_restart_early: tick=%b valid=%b want 0 0", tick3, valid3);
    end
    step(1);
    checks++;
    if (tick3 !== 1'b1) begin
      errors++;
      $display("FAIL dis_restart_tick: tick=%b want 1", tick3);
    end
    step(8);
    checks++;
    if (valid3 !== 1'b0 || light3 !== 1'b1) begin
      errors++;
      $display("FAIL dis_no_early_commit: valid=%b light=%b want 0 1", valid3, light3);
    end
    step(1);
    checks++;
    if ({light3, valid3, night3} !== 3'b011) begin
      errors++;
      $display("FAIL dis_commit: light/valid/night=%b want 011", {light3, valid3, night3});
    end
    enable = 1'b0;
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    checks++;
    if (valid3 !== 1'b0 || light3 !== 1'b0 || tick3 !== 1'b0) begin
      errors++;
      $display("FAIL dis_with_ack: valid=%b light=%b tick=%b want 0 0 0", valid3, light3, tick3);
    end
    step(3);
    enable = 1'b1;
  endtask

  task automatic test_stable_one();
    reset = 1'b0;
    #2;
    checks++;
    if ({light3, valid3, night3, tick3, light1, valid1, night1, tick1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %b want 00000000",
               {light3, valid3, night3, tick3, light1, valid1, night1, tick1});
    end
    sensor_input = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(8);
    align();
    sensor_input = 1'b1;
    step(4);
    checks++;
    if (tick1 !== 1'b1 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL s1_tick: tick=%b valid=%b want 1 0", tick1, valid1);
    end
    step(1);
    checks++;
    if ({light1, valid1, night1} !== 3'b110) begin
      errors++;
      $display("FAIL s1_commit: light/valid/night=%b want 110", {light1, valid1, night1});
    end
    checks++;
    if (valid3 !== 1'b0) begin
      errors++;
      $display("FAIL s3_not_yet: evt_valid=%b want 0", valid3);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_to_day();
    test_glitch_then_night();
    test_back_to_back();
    test_disable();
    test_stable_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_day_night_ctrl.md
Name: light_day_night_ctrl

Overview:
Controller that sequences sampling of the digital LDR sensor input and decides the pet's day/night condition. It synchronizes the raw input, samples it on a prescaled tick, and commits a light/dark change only after STABLE_COUNT consecutive agreeing samples. Each committed change is reported to the pet state machine as a held event with a valid/ack handshake.

Parameters:
SAMPLE_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range >= 2.
STABLE_COUNT, 16, consecutive differing samples required to commit a change; legal range >= 1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
sensor_input  input  1  raw LDR digital input, asynchronous to clk; 1 = light.
enable  input  1  1 = monitoring active.
evt_ack  input  1  consumer acknowledges the pending event.
light_state  output  1  filtered condition; 1 = day/light, 0 = night/dark.
evt_valid  output  1  a committed change is pending acknowledgement.
evt_is_night  output  1  type of the pending event; 1 = light-to-dark, 0 = dark-to-light. Valid only while evt_valid = 1.
sample_tick  output  1  one-cycle pulse on each prescaler tick (debug).

Behaviour:
- Reset (reset = 0, immediate, no clock needed): sync FFs = 0, prescaler = 0, stable counter = 0, FSM = OFF, light_state = 0, evt_valid = 0, evt_is_night = 0, sample_tick = 0.
- Synchronizer: 2-FF chain on sensor_input; the second stage is `samp`. Adds 2 cycles of latency.
- Prescaler: counts 0..SAMPLE_DIV-1 while enable = 1, then wraps to 0. sample_tick = 1 for exactly the cycle in which the count equals SAMPLE_DIV-1. While enable = 0, the count is held at 0 and no ticks are generated.
- Stable counter width = clog2(STABLE_COUNT+1). It never exceeds STABLE_COUNT-1.
- FSM states:
  - OFF: entered from reset, or from any state on the edge where enable = 0. On entry, clear the stable counter and evt_valid. light_state is retained. Move to TRACK on the first edge with enable = 1.
  - TRACK: on a tick with samp == light_state, stay. On a tick with samp != light_state: if STABLE_COUNT == 1, commit; otherwise set counter = 1 and go to CONFIRM.
  - CONFIRM: on a tick with samp == light_state, set counter = 0 and return to TRACK (glitch rejected). On a tick with samp != light_state: if counter == STABLE_COUNT-1, commit; otherwise increment the counter.
  - Commit action (registered, single edge): light_state <= samp; evt_is_night <= ~samp; evt_valid <= 1; counter <= 0; go to NOTIFY.
  - NOTIFY: evt_valid, evt_is_night and light_state are held stable. Ticks still pulse, but samples are ignored. On an edge with evt_ack = 1, set evt_valid <= 0 and go to TRACK. Sampling resumes from a zero count on the next tick.
- Handshake rules:
  - evt_ack is honoured only while evt_valid = 1; otherwise it is ignored.
  - The earliest evt_valid can drop is one cycle after it rises.
  - At most one event is outstanding; a change occurring during NOTIFY is detected only after the ack.
- Latency: from a sensor edge to evt_valid = 1 is 2 sync cycles plus between STABLE_COUNT-1 and STABLE_COUNT tick periods, plus 1 cycle.
- Simultaneous events: enable = 0 takes priority over commit and over ack. The event is discarded and light_state keeps its last committed value.
- Reset asserted mid-operation forces the reset values above asynchronously. After release, the block restarts in OFF.

Test Plan:
1. Bench SAMPLE_DIV=4, STABLE_COUNT=3. Assert reset with sensor=1, then check outputs with no clock edge -> all outputs 0 immediately. Release with enable=1 and sensor=0 for 40 cycles -> evt_valid stays 0, light_state=0, sample_tick pulses every 4th cycle.
2. Drive sensor 0->1 and hold, with evt_ack=0 -> on the 3rd tick that sees samp=1: light_state=1, evt_valid=1, evt_is_night=0; these hold for 20 cycles. Pulse evt_ack for 1 cycle -> evt_valid=0 on the next edge.
3. From light_state=1, drive sensor=0 for 2 ticks, then back to 1 -> no event, light_state stays 1, counter returns to 0. Then drive sensor=0 for 3 ticks -> evt_valid=1, evt_is_night=1, light_state=0.
4. With evt_valid=1 pending, toggle the sensor back and hold for 10 ticks -> no state change. Ack -> a second event fires exactly 3 ticks after the ack, not earlier.
5. In CONFIRM with counter=2, drive enable=0 for 1 cycle and then back to 1 -> no event, prescaler restarts from 0, and a full 3 new ticks are needed to commit. Also drive enable=0 in the same cycle as evt_ack -> evt_valid=0, FSM in OFF.
6. Set STABLE_COUNT=1 and step the sensor -> commit on the first differing tick; evt_valid rises 1 cycle after that tick.
